word_to_byte_streamer: RTL and testbench

Unpacks a 32-bit AXI4-Stream word stream into an 8-bit AXI4-Stream byte stream. It is the transmit-side counterpart of `byte_to_word_streamer`, and it sits between a word-wide DMA/FIFO source and a byte-wide sink such as a UART or serial framer. The block honours `tkeep` by skipping disabled byte lanes. It carries `tlast` onto the final emitted byte of a packet and sustains one byte per clock with no bubbles between words.

---
 rtl/word_to_byte_streamer.sv | 128 ++++++++++++
 tb/tb_word_to_byte_streamer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_to_byte_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : word_to_byte_streamer
//  Brief    : 32-bit AXI4-Stream word to 8-bit byte unpacker, tkeep-aware,
//             full byte rate across word boundaries.
//  Revision : 1.0 - initial release
// ============================================================================
module word_to_byte_streamer #(
    parameter int BIG_ENDIAN = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [31:0]          s_axis_tdata,
    input  logic [3:0]           s_axis_tkeep,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic                 drop_err
);

    logic [31:0]          r_hold_data;
    logic [3:0]           r_hold_keep;
    logic                 r_hold_last;
    logic                 r_ready_en;
    logic [7:0]           r_out_data;
    logic                 r_out_valid;
    logic                 r_out_last;
    logic [CNT_WIDTH-1:0] r_pkt_count;
    logic                 r_drop_err;

    logic [1:0]           w_sel_lane;
    logic [7:0]           w_sel_byte;
    logic [3:0]           w_keep_left;
    logic                 w_hold_full;
    logic                 w_out_free;
    logic                 w_load;
    logic                 w_load_final;
    logic                 w_accept;

    // The lane that wins is the last one the loop hits, so the loop
    // direction is the reverse of emit order.
    always_comb begin
        w_sel_lane = 2'd0;
        if (BIG_ENDIAN != 0) begin
            for (int i = 0; i < 4; i++) begin
                if (r_hold_keep[i]) w_sel_lane = i[1:0];
            end
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (r_hold_keep[i]) w_sel_lane = i[1:0];
            end
        end
    end

    always_comb begin
        case (w_sel_lane)
            2'd0:    w_sel_byte = r_hold_data[7:0];
            2'd1:    w_sel_byte = r_hold_data[15:8];
            2'd2:    w_sel_byte = r_hold_data[23:16];
            default: w_sel_byte = r_hold_data[31:24];
        endcase
    end

    assign w_keep_left  = r_hold_keep & ~(4'b0001 << w_sel_lane);
    assign w_hold_full  = (r_hold_keep != 4'b0000);
    assign w_out_free   = !r_out_valid || m_axis_tready;
    assign w_load       = w_out_free && w_hold_full;
    assign w_load_final = w_load && (w_keep_left == 4'b0000);

    // Accepting while the final lane drains is what removes the bubble
    // between consecutive words.
    assign s_axis_tready = r_ready_en && !ARESET && (!w_hold_full || w_load_final);
    assign w_accept      = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_hold_data <= 32'd0;
            r_hold_keep <= 4'b0000;
            r_hold_last <= 1'b0;
            r_ready_en  <= 1'b0;
            r_out_data  <= 8'd0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_pkt_count <= '0;
            r_drop_err  <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;

            if (w_accept) begin
                r_hold_data <= s_axis_tdata;
                r_hold_keep <= s_axis_tkeep;
                r_hold_last <= s_axis_tlast;
            end else if (w_load) begin
                r_hold_keep <= w_keep_left;
            end

            if (w_load) begin
                r_out_data  <= w_sel_byte;
                r_out_valid <= 1'b1;
                r_out_last  <= r_hold_last && (w_keep_left == 4'b0000);
            end else if (r_out_valid && m_axis_tready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end

            // A zero-keep tlast word carries nothing, so its end-of-packet is lost.
            r_drop_err <= w_accept && (s_axis_tkeep == 4'b0000) && s_axis_tlast;

            if (r_out_valid && m_axis_tready && r_out_last) begin
                r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
            end
        end
    end

    assign m_axis_tdata  = r_out_data;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tlast  = r_out_last;
    assign pkt_count     = r_pkt_count;
    assign drop_err      = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_word_to_byte_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_word_to_byte_streamer
//  Brief    : Self-checking bench; big- and little-endian instances share one
//             stimulus stream and are scored against a byte-queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_word_to_byte_streamer;

    logic             ACLK = 1'b0;
    logic             ARESET;
    logic [31:0]      s_axis_tdata;
    logic [3:0]       s_axis_tkeep;
    logic             s_axis_tlast;
    logic             s_axis_tvalid;
    logic             m_axis_tready;
    logic [1:0]       s_ready;
    logic [1:0][7:0]  m_data;
    logic [1:0]       m_last;
    logic [1:0]       m_valid;
    logic [1:0][15:0] pcnt;
    logic [1:0]       drop;

    always #5 ACLK = ~ACLK;

    word_to_byte_streamer #(.BIG_ENDIAN(1), .CNT_WIDTH(16)) u_dut_be (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_ready[0]),
        .m_axis_tdata(m_data[0]), .m_axis_tlast(m_last[0]),
        .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_axis_tready),
        .pkt_count(pcnt[0]), .drop_err(drop[0])
    );

    word_to_byte_streamer #(.BIG_ENDIAN(0), .CNT_WIDTH(16)) u_dut_le (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_ready[1]),
        .m_axis_tdata(m_data[1]), .m_axis_tlast(m_last[1]),
        .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_axis_tready),
        .pkt_count(pcnt[1]), .drop_err(drop[1])
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } byte_t;

    int          checks = 0;
    int          failures = 0;
    byte_t       q[2][$];
    logic [15:0] exp_pkt[2];
    logic        exp_drop;
    logic        stall[2];
    logic [7:0]  sd[2];
    logic        sl[2];
    int          hs_cnt, first_hs, last_hs;
    int          cyc = 0;
    logic        last_acc;
    int          acc_log[$];
    int          drop_seen = 0;
    int          mode = 0;
    int          pc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a word expands into its kept bytes in emit order,
    // the final kept byte of a tlast word carries tlast.
    task automatic push_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        for (int inst = 0; inst < 2; inst++) begin
            int seen = 0;
            for (int j = 0; j < 4; j++) begin
                int lane = (inst == 0) ? 3 - j : j;
                if (k[lane]) begin
                    byte_t b;
                    seen++;
                    b.d = d[lane*8 +: 8];
                    b.l = l && (seen == $countones(k));
                    q[inst].push_back(b);
                end
            end
        end
    endtask

    task automatic mon_inst(input int k);
        if (stall[k]) begin
            check($sformatf("stall_data%0d", k), 32'(m_data[k]), 32'(sd[k]));
            check($sformatf("stall_last%0d", k), 32'(m_last[k]), 32'(sl[k]));
        end
        check($sformatf("pkt_count%0d", k), 32'(pcnt[k]), 32'(exp_pkt[k]));
        check($sformatf("drop_err%0d", k), 32'(drop[k]), 32'(exp_drop));
        if (m_valid[k] && m_axis_tready) begin
            checks++;
            assert (q[k].size() != 0) else begin
                failures++;
                $error("FAIL extra_byte%0d observed=%0h expected=none", k, m_data[k]);
            end
            if (q[k].size() != 0) begin
                byte_t e = q[k].pop_front();
                check($sformatf("byte%0d", k), 32'(m_data[k]), 32'(e.d));
                check($sformatf("tlast%0d", k), 32'(m_last[k]), 32'(e.l));
                if (e.l) exp_pkt[k] = exp_pkt[k] + 16'd1;
                if (k == 0) begin
                    if (hs_cnt == 0) first_hs = cyc;
                    hs_cnt++;
                    last_hs = cyc;
                end
            end
        end
        stall[k] = m_valid[k] && !m_axis_tready;
        sd[k]    = m_data[k];
        sl[k]    = m_last[k];
    endtask

    task automatic tick();
        @(negedge ACLK);
        if (ARESET) begin
            for (int k = 0; k < 2; k++) begin
                q[k].delete();
                exp_pkt[k] = 16'd0;
                stall[k]   = 1'b0;
            end
            exp_drop = 1'b0;
            last_acc = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) mon_inst(k);
            if (drop[0]) drop_seen++;
            last_acc = s_axis_tvalid && s_ready[0];
            exp_drop = last_acc && (s_axis_tkeep == 4'b0000) && s_axis_tlast;
            if (last_acc) begin
                push_word(s_axis_tdata, s_axis_tkeep, s_axis_tlast);
                acc_log.push_back(cyc);
            end
        end
        @(posedge ACLK);
        #1;
        cyc++;
        case (mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ($urandom_range(0, 3) != 0);
            default: begin
                m_axis_tready = (pc < 6) ? ((pc % 2) == 1) : (pc >= 11);
                pc++;
            end
        endcase
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        bit done = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            tick();
            done = last_acc;
        end
        if (!done) begin
            checks++;
            failures++;
            $error("FAIL send_timeout observed=no_accept expected=accept data=%0h", d);
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int i = 0;
        while (i < 400 && (q[0].size() != 0 || q[1].size() != 0 || m_valid != 2'b00)) begin
            tick();
            i++;
        end
        check("drain_be", q[0].size(), 0);
        check("drain_le", q[1].size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        ARESET        = 1'b1;
        s_axis_tdata  = 32'd0;
        s_axis_tkeep  = 4'd0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        exp_drop      = 1'b0;
        hs_cnt        = 0;
        first_hs      = 0;
        last_hs       = 0;
        last_acc      = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_pkt[k] = 16'd0; stall[k] = 1'b0; sd[k] = 8'd0; sl[k] = 1'b0;
        end

        // Reset values
        repeat (3) tick();
        check("rst_tready", 32'(s_ready[0]), 0);
        check("rst_tvalid", 32'(m_valid), 0);
        check("rst_tdata", 32'(m_data[0]), 0);
        check("rst_tlast", 32'(m_last), 0);
        check("rst_pkt", 32'(pcnt[0]), 0);
        check("rst_drop", 32'(drop), 0);
        ARESET = 1'b0;
        check("tready_pre_edge", 32'(s_ready[0]), 0);
        tick();
        check("tready_post_edge", 32'(s_ready), 32'h3);

        // Single full word; both byte orders at once, plus first-byte latency
        send_word(32'hA1B2C3D4, 4'hF, 1'b1);
        check("lat_hold", 32'(m_valid[0]), 0);
        tick();
        check("lat_valid", 32'(m_valid), 32'h3);
        check("first_be", 32'(m_data[0]), 32'hA1);
        check("first_le", 32'(m_data[1]), 32'hD4);
        drain();
        check("pkt1_be", 32'(pcnt[0]), 1);
        check("pkt1_le", 32'(pcnt[1]), 1);

        // Back-to-back words at full byte rate
        hs_cnt = 0;
        acc_log.delete();
        send_word(32'h01020304, 4'hF, 1'b0);
        send_word(32'h05060708, 4'hF, 1'b0);
        send_word(32'h090A0B0C, 4'hF, 1'b1);
        drain();
        check("tp_accepts", acc_log.size(), 3);
        if (acc_log.size() == 3) begin
            check("tp_gap1", acc_log[1] - acc_log[0], 4);
            check("tp_gap2", acc_log[2] - acc_log[1], 4);
        end
        check("tp_bytes", hs_cnt, 12);
        check("tp_span", last_hs - first_hs, 11);

        // Sparse keep
        send_word(32'h11223344, 4'b0101, 1'b1);
        tick();
        check("sparse_be", 32'(m_data[0]), 32'h22);
        check("sparse_le", 32'(m_data[1]), 32'h44);
        drain();
        check("pkt3", 32'(pcnt[0]), 3);

        // Backpressure: toggle then a long stall across a 2-word packet
        mode = 2;
        pc = 0;
        m_axis_tready = 1'b0;
        base = hs_cnt;
        send_word(32'hDEADBEEF, 4'hF, 1'b0);
        send_word(32'h0BADCAFE, 4'hF, 1'b1);
        drain();
        check("bp_bytes", hs_cnt - base, 8);
        check("pkt4", 32'(pcnt[0]), 4);
        mode = 0;
        m_axis_tready = 1'b1;

        // Zero-keep tlast word
        base = drop_seen;
        send_word(32'h12345678, 4'b0000, 1'b1);
        repeat (3) tick();
        check("drop_pulses", drop_seen - base, 1);
        check("drop_pkt", 32'(pcnt[0]), 4);
        check("drop_idle", 32'(m_valid), 0);

        // Reset after two of four bytes
        base = hs_cnt;
        send_word(32'h55667788, 4'hF, 1'b1);
        for (int i = 0; i < 20 && (hs_cnt - base) < 2; i++) tick();
        check("mid_bytes", hs_cnt - base, 2);
        ARESET = 1'b1;
        tick();
        check("mid_rst_valid", 32'(m_valid), 0);
        check("mid_rst_pkt", 32'(pcnt[0]), 0);
        ARESET = 1'b0;
        tick();
        check("mid_idle", 32'(m_valid), 0);
        send_word(32'hCAFEF00D, 4'hF, 1'b1);
        drain();
        check("post_rst_pkt_be", 32'(pcnt[0]), 1);
        check("post_rst_pkt_le", 32'(pcnt[1]), 1);

        // Randomized words, keeps, gaps and sink readiness
        mode = 1;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_word($urandom, 4'($urandom_range(0, 15)), (n == 39) || ($urandom_range(0, 3) == 0));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
